// File: rtl/module_scan_keypad.sv
// 4x4 matrix keypad scanner: one-cold column drive, synchronized row sampling, press/release
// debounce, key encoding and a valid/ack hand-off. Define KEYPAD_AUTOREPEAT_EN for held-key repeat.
module module_scan_keypad #(
  parameter int DWELL_CYC = 27000,
  parameter int DB_CNT    = 8
`ifdef KEYPAD_AUTOREPEAT_EN
  , parameter int REPEAT_DWELLS = 500
`endif
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] row_i,
  input  logic       key_ack_i,
  output logic [3:0] column_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o,
  output logic       overrun_o
);

  localparam int DW_W = $clog2(DWELL_CYC);
  localparam int DB_W = $clog2(DB_CNT + 1);
  localparam logic [1:0] S_SCAN = 2'd0, S_DEB = 2'd1, S_HELD = 2'd2;
  // Nibble {row,col} -> key code; row 3 holds * 0 # D.
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  logic [3:0]      row_s1_q, row_s2_q;
  logic [DW_W-1:0] dwell_q;
  logic [1:0]      state_q, state_d, col_q, col_d, row_lat_q, row_lat_d;
  logic [DB_W-1:0] db_q, db_d;
  logic            held_q, held_d;
  logic [3:0]      key_code_q;
  logic            key_valid_q, overrun_q;
  logic            sample, one_low, all_high, emit;
  logic [1:0]      row_idx;
  logic [3:0]      enc_code;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RP_W = $clog2(REPEAT_DWELLS + 1);
  logic [RP_W-1:0] rep_q, rep_d;
`endif

  assign sample   = (dwell_q == DW_W'(DWELL_CYC - 1));
  assign all_high = (row_s2_q == 4'hF);
  assign enc_code = KEYMAP[{row_lat_q, col_q, 2'b00} +: 4];

  always_comb begin
    one_low = 1'b1;
    row_idx = 2'd0;
    case (row_s2_q)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_lat_d = row_lat_q;
    db_d      = db_q;
    held_d    = held_q;
    emit      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d     = rep_q;
`endif
    if (sample) begin
      case (state_q)
        S_SCAN: begin
          if (one_low) begin
            row_lat_d = row_idx;
            db_d      = DB_W'(1);
            state_d   = S_DEB;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        S_DEB: begin
          if (one_low && row_idx == row_lat_q) begin
            if (db_q == DB_W'(DB_CNT - 1)) begin
              emit    = 1'b1;
              held_d  = 1'b1;
              db_d    = '0;
              state_d = S_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_d   = '0;
`endif
            end else begin
              db_d = db_q + 1'b1;
            end
          end else begin
            col_d   = col_q + 2'd1;
            db_d    = '0;
            state_d = S_SCAN;
          end
        end
        S_HELD: begin
          // db_q now counts consecutive released samples.
          if (all_high) begin
            if (db_q == DB_W'(DB_CNT - 1)) begin
              held_d  = 1'b0;
              db_d    = '0;
              col_d   = col_q + 2'd1;
              state_d = S_SCAN;
            end else begin
              db_d = db_q + 1'b1;
            end
          end else begin
            db_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rep_q == RP_W'(REPEAT_DWELLS - 1)) begin
              emit  = 1'b1;
              rep_d = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
`endif
          end
        end
        default: state_d = S_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      dwell_q     <= '0;
      state_q     <= S_SCAN;
      col_q       <= 2'd0;
      row_lat_q   <= 2'd0;
      db_q        <= '0;
      held_q      <= 1'b0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      row_s1_q  <= row_i;
      row_s2_q  <= row_s1_q;
      dwell_q   <= sample ? '0 : dwell_q + 1'b1;
      state_q   <= state_d;
      col_q     <= col_d;
      row_lat_q <= row_lat_d;
      db_q      <= db_d;
      held_q    <= held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q     <= rep_d;
`endif
      // An ack on the emit edge frees the slot for the new code.
      if (emit) begin
        if (!key_valid_q || key_ack_i) begin
          key_code_q  <= enc_code;
          key_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (key_ack_i) begin
        key_valid_q <= 1'b0;
      end
    end
  end

  assign column_o    = ~(4'b0001 << col_q);
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = held_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_module_scan_keypad.sv
// Bench for module_scan_keypad: keypad matrix model, emission scoreboard, timing and handshake checks.
module tb_module_scan_keypad;
  localparam int DW = 4;
  localparam int DB = 3;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HOLD_DWELLS = 3;
`else
  localparam int HOLD_DWELLS = 40;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] row, column, key_code;
  logic key_ack, key_valid, key_held, overrun;
  logic [15:0] pressed = '0;
  logic man_ack = 1'b0, ack_auto = 1'b0, auto_ack = 1'b0;
  logic prev_valid = 1'b0, prev_ack = 1'b0;
  int n_vec = 0, n_err = 0;
  logic [3:0] sb_q[$];

  always #5 clk = ~clk;

  module_scan_keypad #(
    .DWELL_CYC(DW), .DB_CNT(DB)
`ifdef KEYPAD_AUTOREPEAT_EN
    , .REPEAT_DWELLS(5)
`endif
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .row_i(row), .key_ack_i(key_ack),
    .column_o(column), .key_code_o(key_code), .key_valid_o(key_valid),
    .key_held_o(key_held), .overrun_o(overrun)
  );

  // Passive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !column[c]) row[r] = 1'b0;
  end

  assign key_ack = ack_auto | man_ack;
  always @(posedge clk) begin
    #1 ack_auto = auto_ack & key_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // A new code is presented when valid rises or stays high across an accepted ack.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (key_valid && (!prev_valid || prev_ack)) begin
        if (sb_q.size() == 0) chk("emit_unexpected", sb_q.size(), 1);
        else chk("emit_code", key_code, sb_q.pop_front());
      end
      prev_valid = key_valid;
      prev_ack   = key_ack;
    end
  end

  task automatic wait_col(input int c, input string tag);
    logic [3:0] want;
    want = ~(4'b0001 << c);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (column === want) break;
    end
    chk(tag, column, want);
  endtask

  task automatic wait_sig(input int which, input logic val, input string tag);
    logic cur;
    cur = ~val;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      cur = (which == 0) ? key_valid : key_held;
      if (cur === val) break;
    end
    chk(tag, cur, val);
  endtask

  // Press so that the key's column is entered on the next scan step; returns at the negedge after it.
  task automatic press_at(input int r, input int c);
    wait_col((c + 3) % 4, "align_pre");
    pressed[r*4+c] = 1'b1;
    wait_col(c, "align_col");
  endtask

  task automatic release_all(input string tag);
    pressed = '0;
    wait_sig(1, 1'b0, tag);
  endtask

  initial begin
    // reset values, then a mid-scan reset and the rotation cadence
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_col", column, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_code", key_code, 0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midrst_col", column, 4'b1110);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) chk("rot_hold", column, 4'b1110);
    @(posedge clk);
    @(negedge clk) chk("rot_1", column, 4'b1101);
    repeat (4) @(posedge clk);
    @(negedge clk) chk("rot_2", column, 4'b1011);

    // clean press of '5' with exact emit latency, auto ack, long hold, release
    auto_ack = 1'b1;
    sb_q.push_back(4'd5);
    press_at(1, 1);
    repeat (11) @(posedge clk);
    @(negedge clk) chk("lat_pre", key_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_emit", key_valid, 1);
    chk("held_set", key_held, 1);
    @(posedge clk);
    @(negedge clk) chk("ack_clr", key_valid, 0);
    repeat (HOLD_DWELLS * DW) @(posedge clk);
    chk("held_long", key_held, 1);
    pressed = '0;
    repeat (8) @(posedge clk);
    @(negedge clk) chk("rel_early", key_held, 1);
    wait_sig(1, 1'b0, "rel_held");

    // bounce: two confirming samples, then release before the third
    press_at(1, 1);
    repeat (9) @(posedge clk);
    @(negedge clk) pressed = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bounce_rot", column, 4'b1011);
    chk("bounce_valid", key_valid, 0);
    chk("bounce_held", key_held, 0);

    // ghosting: rows 0 and 2 low together in column 1
    pressed[0*4+1] = 1'b1;
    pressed[2*4+1] = 1'b1;
    repeat (20 * DW) @(posedge clk);
    wait_col(1, "ghost_c1");
    repeat (4) @(negedge clk);
    chk("ghost_adv", column, 4'b1011);
    chk("ghost_held", key_held, 0);
    pressed = '0;

    // overrun: '1' left pending, then 'A' is lost
    auto_ack = 1'b0;
    sb_q.push_back(4'd1);
    pressed[0] = 1'b1;
    wait_sig(0, 1'b1, "ovr_first");
    release_all("ovr_rel1");
    press_at(0, 3);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("ovr_code", key_code, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", key_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("ovr_rst_valid", key_valid, 0);
    chk("ovr_rst_flag", overrun, 0);
    pressed = '0;
    @(negedge clk) rst_n = 1'b1;

    // same sequence, ack lands on the 'A' emit edge
    sb_q.push_back(4'd1);
    pressed[0] = 1'b1;
    wait_sig(0, 1'b1, "ack_first");
    release_all("ack_rel1");
    press_at(0, 3);
    repeat (11) @(posedge clk);
    #1 man_ack = 1'b1;
    sb_q.push_back(4'd10);
    @(posedge clk);
    #1 man_ack = 1'b0;
    @(negedge clk);
    chk("same_edge_code", key_code, 10);
    chk("same_edge_valid", key_valid, 1);
    chk("same_edge_ovr", overrun, 0);
    auto_ack = 1'b1;
    release_all("ack_rel2");

    // reset during DEBOUNCE, key kept down: full re-debounce afterwards
    sb_q.push_back(4'd4);
    press_at(1, 0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("deb_rst_col", column, 4'b1110);
    chk("deb_rst_held", key_held, 0);
    chk("deb_rst_valid", key_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk) chk("rdb_pre", key_valid, 0);
    @(posedge clk);
    @(negedge clk) chk("rdb_emit", key_valid, 1);
    release_all("rdb_rel");

`ifdef KEYPAD_AUTOREPEAT_EN
    // hold 'D': re-emitted every 5 dwells
    sb_q.push_back(4'd13);
    pressed[3*4+3] = 1'b1;
    wait_sig(0, 1'b1, "rep_first");
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back(4'd13);
      repeat (19) @(posedge clk);
      @(negedge clk) chk("rep_gap", key_valid, 0);
      @(posedge clk);
      @(negedge clk) chk("rep_emit", key_valid, 1);
    end
    release_all("rep_rel");
`endif

    repeat (8) @(posedge clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
